// File: rtl/cornerupdate_accel_mul_pipe_sat.sv
// Pipelined signed multiplier with valid/ready flow control, round-to-nearest
// right shift and signed saturation. All stages advance together on a global
// stall signal, so there is no bubble compression and no skid buffer.
module cornerupdate_accel_mul_pipe_sat #(
    parameter int A_WIDTH   = 16,
    parameter int A_SIGNED  = 0,
    parameter int B_WIDTH   = 16,
    parameter int P_WIDTH   = 22,
    parameter int SHIFT     = 8,
    parameter int NUM_STAGE = 4   // legal range 2..6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] din0,
    input  logic [B_WIDTH-1:0] din1,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [P_WIDTH-1:0] dout,
    output logic               sat
);

    // Full exact product width: A is widened by one bit so unsigned A fits as signed.
    localparam int FW  = A_WIDTH + B_WIDTH + 1;
    // Number of product register stages between the operand stage and the output stage.
    localparam int NPS = NUM_STAGE - 2;
    // Working width for rounding/compare: room for the rounding carry and for the
    // P_WIDTH limits, plus a sign bit.
    localparam int W   = ((FW + 1 > P_WIDTH) ? FW + 1 : P_WIDTH) + 1;

    localparam logic signed [W-1:0] RND   = (SHIFT > 0) ? (W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [W-1:0] P_MAX = (W'(1) << (P_WIDTH - 1)) - W'(1);
    localparam logic signed [W-1:0] P_MIN = -(W'(1) << (P_WIDTH - 1));

    // Exact signed multiply at full product width.
    function automatic logic signed [FW-1:0] mul(input logic signed [A_WIDTH:0]   a,
                                                 input logic signed [B_WIDTH-1:0] b);
        logic signed [FW-1:0] aw;
        logic signed [FW-1:0] bw;
        aw = {{B_WIDTH{a[A_WIDTH]}}, a};
        bw = {{(A_WIDTH + 1){b[B_WIDTH-1]}}, b};
        return aw * bw;
    endfunction

    // Round half toward +inf, arithmetic shift, then clip; returns {sat, dout}.
    function automatic logic [P_WIDTH:0] round_sat(input logic signed [FW-1:0] p);
        logic signed [W-1:0] ext;
        logic signed [W-1:0] r;
        ext = {{(W - FW){p[FW-1]}}, p};
        r   = (ext + RND) >>> SHIFT;
        if (r > P_MAX)      return {1'b1, P_MAX[P_WIDTH-1:0]};
        else if (r < P_MIN) return {1'b1, P_MIN[P_WIDTH-1:0]};
        else                return {1'b0, r[P_WIDTH-1:0]};
    endfunction

    logic                      adv;
    logic signed [A_WIDTH:0]   a_ext;
    logic signed [A_WIDTH:0]   a_r;
    logic signed [B_WIDTH-1:0] b_r;
    logic                      v1;
    logic signed [FW-1:0]      tail_prod;
    logic                      tail_valid;
    logic [P_WIDTH:0]          rs;

    // Global stall: everything moves only when the output slot is free or draining.
    assign adv      = ce & (~out_valid | out_ready);
    assign in_ready = adv;

    // Widen operand A according to its signedness.
    always_comb begin
        a_ext = (A_SIGNED != 0) ? {din0[A_WIDTH-1], din0} : {1'b0, din0};
    end

    // S1: register operands and the input valid bit.
    // NOTE: data registers are reset along with the valid bits so dout is a defined 0
    // after reset; the valid bits alone decide what is meaningful.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1  <= 1'b0;
            a_r <= '0;
            b_r <= '0;
        end else if (adv) begin
            v1  <= in_valid;
            a_r <= a_ext;
            b_r <= din1;
        end
    end

    generate
        if (NUM_STAGE == 2) begin : g_direct
            // Multiply and round/saturate share the output stage.
            assign tail_prod  = mul(a_r, b_r);
            assign tail_valid = v1;
        end else begin : g_pipe
            logic signed [FW-1:0] p_q [NPS];
            logic [NPS-1:0]       v_q;

            // S2 and extra stages: register the product and shift it down the line.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v_q <= '0;
                    for (int i = 0; i < NPS; i++) p_q[i] <= '0;
                end else if (adv) begin
                    p_q[0] <= mul(a_r, b_r);
                    v_q[0] <= v1;
                    for (int i = 1; i < NPS; i++) begin
                        p_q[i] <= p_q[i-1];
                        v_q[i] <= v_q[i-1];
                    end
                end
            end

            assign tail_prod  = p_q[NPS-1];
            assign tail_valid = v_q[NPS-1];
        end
    endgenerate

    assign rs = round_sat(tail_prod);

    // Last stage: register the rounded, saturated result and its valid bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            dout      <= '0;
            sat       <= 1'b0;
        end else if (adv) begin
            out_valid <= tail_valid;
            sat       <= rs[P_WIDTH];
            dout      <= rs[P_WIDTH-1:0];
        end
    end

endmodule
